// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I decode with a main+skid output buffer.
// Decode is combinational on in_instr. The result is captured into the main
// entry, or into the skid entry when the main entry is stalled.
//
// Buffer state (bit0 = main_v, bit1 = skid_v):
//   state   | meaning
//   S_EMPTY | no entry held; in_ready=1, out_valid=0
//   S_ONE   | main entry held; in_ready=1, out_valid=1
//   S_FULL  | main and skid held; in_ready=0, out_valid=1
module rv_decode_stage #(
  parameter int XLEN       = 32,
  parameter bit ZERO_RD_WB = 1'b0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_func3,
  output logic            out_funcqual,
  output logic            out_alusel1,
  output logic            out_alusel2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_wb_en,
  output logic [8:0]      out_class,
  output logic            out_illegal
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      func3;
    logic            funcqual;
    logic            alusel1;
    logic            alusel2;
    logic [XLEN-1:0] imm;
    logic            wb_en;
    logic [8:0]      cls;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b11
  } state_t;

  state_t      state, state_nx;
  entry_t      dec, main_q, skid_q;
  logic [4:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic [8:0]  cls;
  logic        ill, wb;
  logic        accept, consume;
  logic        ld_main_in, ld_main_skid, ld_skid;

  assign opc = in_instr[6:2];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  // Decode the presented instruction word into a buffer entry.
  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.rd    = in_instr[11:7];
    dec.rs1   = in_instr[19:15];
    dec.func3 = f3;
    imm32     = '0;
    cls       = '0;
    ill       = 1'b0;
    wb        = 1'b0;
    case (opc)
      OPC_LOAD: begin
        cls[3] = 1'b1; wb = 1'b1; dec.alusel2 = 1'b1; imm32 = imm_i;
        ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        cls[4] = 1'b1; dec.rs2 = in_instr[24:20]; dec.alusel2 = 1'b1; imm32 = imm_s;
        ill = (f3 > 3'b010);
      end
      OPC_BRANCH: begin
        cls[5] = 1'b1; dec.rs2 = in_instr[24:20]; imm32 = imm_b;
        ill = (f3[2:1] == 2'b01);
      end
      OPC_JALR: begin
        cls[7] = 1'b1; wb = 1'b1; dec.alusel2 = 1'b1; imm32 = imm_i;
        ill = (f3 != 3'b000);
      end
      OPC_JAL: begin
        cls[6] = 1'b1; wb = 1'b1; dec.alusel1 = 1'b1; dec.alusel2 = 1'b1; imm32 = imm_j;
      end
      OPC_LUI: begin
        cls[1] = 1'b1; wb = 1'b1; dec.alusel2 = 1'b1; dec.rs1 = 5'd0; imm32 = imm_u;
      end
      OPC_AUIPC: begin
        cls[2] = 1'b1; wb = 1'b1; dec.alusel1 = 1'b1; dec.alusel2 = 1'b1; imm32 = imm_u;
      end
      OPC_OP: begin
        cls[0] = 1'b1; wb = 1'b1; dec.rs2 = in_instr[24:20]; dec.funcqual = in_instr[30];
        ill = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OPIMM: begin
        cls[0] = 1'b1; wb = 1'b1; dec.alusel2 = 1'b1; imm32 = imm_i;
        if (f3 == 3'b001) begin
          dec.funcqual = in_instr[30];
          ill = (f7 != 7'h00);
        end else if (f3 == 3'b101) begin
          dec.funcqual = in_instr[30];
          ill = (f7 != 7'h00) && (f7 != 7'h20);
        end
      end
      OPC_SYSTEM, OPC_FENCE: cls[8] = 1'b1;
      default: ill = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) ill = 1'b1;
    if (!ZERO_RD_WB && (dec.rd == 5'd0)) wb = 1'b0;
    if (ill) begin
      wb  = 1'b0;
      cls = '0;
    end
    dec.imm     = XLEN'($signed(imm32));
    dec.wb_en   = wb;
    dec.cls     = cls;
    dec.illegal = ill;
  end

  assign accept  = in_valid && in_ready && !flush;
  assign consume = out_valid && out_ready;

  // Buffer state register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_EMPTY;
    else         state <= state_nx;
  end

  // Buffer next-state; flush empties both entries.
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (accept) state_nx = S_ONE;
        S_ONE: begin
          if (accept && !consume)      state_nx = S_FULL;
          else if (!accept && consume) state_nx = S_EMPTY;
        end
        S_FULL:  if (consume) state_nx = S_ONE;
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  // Handshake outputs and entry load strobes decoded from the current state.
  always_comb begin
    out_valid    = state[0];
    in_ready     = !state[1];
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      S_EMPTY: ld_main_in = accept;
      S_ONE: begin
        ld_main_in = accept && consume;
        ld_skid    = accept && !consume;
      end
      S_FULL:  ld_main_skid = consume;
      default: ;
    endcase
  end

  // Entry payload registers; main only changes on load, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)        main_q <= dec;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= dec;
    end
  end

  assign out_pc       = main_q.pc;
  assign out_rd       = main_q.rd;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_func3    = main_q.func3;
  assign out_funcqual = main_q.funcqual;
  assign out_alusel1  = main_q.alusel1;
  assign out_alusel2  = main_q.alusel2;
  assign out_imm      = main_q.imm;
  assign out_wb_en    = main_q.wb_en;
  assign out_class    = main_q.cls;
  assign out_illegal  = main_q.illegal;

endmodule
